anel_monitor: RTL and testbench

ANEL_MONITOR -- requirements
Module: anel_monitor

---
 rtl/anel_monitor_pkg.sv | 17 +
 rtl/anel_monitor_onehot_check.sv | 22 ++
 rtl/anel_monitor.sv | 120 ++++++++++++
 tb/tb_anel_monitor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/anel_monitor_pkg.sv
// Shared definitions for the ring-counter monitor: FSM state encoding and
// error codes reported on err_code.
package anel_monitor_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_ONEHOT = 2'b01;
  localparam logic [1:0] ERR_SEQ    = 2'b10;

  localparam int unsigned PHASE_W = 3;

endpackage

// File: rtl/anel_monitor_onehot_check.sv
// Combinational one-hot classifier: flags a single hot bit and returns its
// binary position.
module onehot_check
  import anel_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned IDX_W = PHASE_W
) (
  input  logic [WIDTH-1:0] q,
  output logic             is_onehot,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    is_onehot = (q != '0) && ((q & (q - WIDTH'(1))) == '0);
    index     = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (q[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/anel_monitor.sv
// Monitors a one-hot ring counter: locks onto its rotation, counts complete
// revolutions and latches a sticky fault on any illegal or out-of-order state.
module anel_monitor
  import anel_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] q_in,
  input  logic             en,
  input  logic             clr_err,
  output logic             locked,
  output logic [2:0]       phase,
  output logic             wrap,
  output logic [CNT_W-1:0] rev_count,
  output logic             rev_ovf,
  output logic             error,
  output logic [1:0]       err_code
);

  state_t           state, state_next;
  logic [WIDTH-1:0] prev, prev_next, expected;
  logic [2:0]       phase_next, idx;
  logic             wrap_next, ovf_next, is_onehot, in_seq;
  logic [CNT_W-1:0] count_next;
  logic [1:0]       code_next;

  onehot_check #(
    .WIDTH (WIDTH),
    .IDX_W (3)
  ) u_onehot (
    .q         (q_in),
    .is_onehot (is_onehot),
    .index     (idx)
  );

  assign expected = {prev[WIDTH-2:0], prev[WIDTH-1]};
  assign in_seq   = is_onehot && (q_in == expected);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= SEARCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    code_next  = err_code;
    if (en) begin
      unique case (state)
        SEARCH: if (is_onehot) state_next = LOCKED;
        LOCKED: begin
          if (!is_onehot) begin
            state_next = FAULT;
            code_next  = ERR_ONEHOT;
          end else if (!in_seq) begin
            state_next = FAULT;
            code_next  = ERR_SEQ;
          end
        end
        FAULT: begin
          if (clr_err) begin
            state_next = SEARCH;
            code_next  = ERR_NONE;
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  // Datapath next values; the revolution count only advances on an in-sequence
  // return to bit 0 while already locked, so the locking sample never wraps.
  always_comb begin
    prev_next  = prev;
    phase_next = phase;
    wrap_next  = 1'b0;
    count_next = rev_count;
    ovf_next   = rev_ovf;
    if (en) begin
      if (state == SEARCH && is_onehot) begin
        prev_next  = q_in;
        phase_next = idx;
      end else if (state == LOCKED && in_seq) begin
        prev_next  = q_in;
        phase_next = idx;
        if (q_in[0]) begin
          wrap_next  = 1'b1;
          count_next = rev_count + CNT_W'(1);
          if (rev_count == '1) ovf_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      prev      <= '0;
      phase     <= '0;
      wrap      <= 1'b0;
      rev_count <= '0;
      rev_ovf   <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      prev      <= prev_next;
      phase     <= phase_next;
      wrap      <= wrap_next;
      rev_count <= count_next;
      rev_ovf   <= ovf_next;
      err_code  <= code_next;
    end
  end

  always_comb begin
    locked = (state == LOCKED);
    error  = (state == FAULT);
  end

endmodule

// File: tb/tb_anel_monitor.sv
// Randomised and directed bench for anel_monitor against a revolution-level
// reference model; a second instance with a 2-bit counter exercises overflow.
module tb_anel_monitor;

  logic       clk = 1'b0;
  logic       clear_n;
  logic [5:0] q_in;
  logic       en, clr_err;

  logic       locked, wrap, rev_ovf, error;
  logic [2:0] phase;
  logic [7:0] rev_count;
  logic [1:0] err_code;

  logic       locked2, wrap2, rev_ovf2, error2;
  logic [2:0] phase2;
  logic [1:0] rev_count2, err_code2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_locked, m_fault, m_wrap;
  int m_last, m_phase, m_code, m_revs;

  anel_monitor dut (
    .clk(clk), .clear_n(clear_n), .q_in(q_in), .en(en), .clr_err(clr_err),
    .locked(locked), .phase(phase), .wrap(wrap), .rev_count(rev_count),
    .rev_ovf(rev_ovf), .error(error), .err_code(err_code)
  );

  anel_monitor #(.WIDTH(6), .CNT_W(2)) dut2 (
    .clk(clk), .clear_n(clear_n), .q_in(q_in), .en(en), .clr_err(clr_err),
    .locked(locked2), .phase(phase2), .wrap(wrap2), .rev_count(rev_count2),
    .rev_ovf(rev_ovf2), .error(error2), .err_code(err_code2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int position(input int q);
    int p = 0;
    for (int i = 0; i < 6; i++) if (q == (1 << i)) p = i;
    return p;
  endfunction

  function automatic int next_of(input int q);
    return ((q * 2) % 64) + (q / 32);
  endfunction

  task automatic model_reset();
    m_locked = 0; m_fault = 0; m_wrap = 0;
    m_last = 0; m_phase = 0; m_code = 0; m_revs = 0;
  endtask

  task automatic model_step(input int q, input bit e, input bit c);
    m_wrap = 0;
    if (!e) return;
    if (m_fault) begin
      if (c) begin m_fault = 0; m_code = 0; end
    end else if (!m_locked) begin
      if ($countones(q) == 1) begin
        m_locked = 1; m_last = q; m_phase = position(q);
      end
    end else if ($countones(q) != 1) begin
      m_locked = 0; m_fault = 1; m_code = 1;
    end else if (q != next_of(m_last)) begin
      m_locked = 0; m_fault = 1; m_code = 2;
    end else begin
      m_last = q; m_phase = position(q);
      if (q == 1) begin m_revs++; m_wrap = 1; end
    end
  endtask

  task automatic check_all();
    check("locked",    int'(locked),     int'(m_locked));
    check("error",     int'(error),      int'(m_fault));
    check("err_code",  int'(err_code),   m_code);
    check("phase",     int'(phase),      m_phase);
    check("wrap",      int'(wrap),       int'(m_wrap));
    check("rev_count", int'(rev_count),  m_revs % 256);
    check("rev_ovf",   int'(rev_ovf),    int'(m_revs >= 256));
    check("wrap2",     int'(wrap2),      int'(m_wrap));
    check("rev_cnt2",  int'(rev_count2), m_revs % 4);
    check("rev_ovf2",  int'(rev_ovf2),   int'(m_revs >= 4));
  endtask

  // Called just after a falling edge; reset acts mid-cycle.
  task automatic do_reset();
    clear_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 clear_n = 1'b1;
  endtask

  task automatic step(input logic [5:0] q, input logic e, input logic c);
    q_in = q; en = e; clr_err = c;
    @(posedge clk);
    model_step(int'(q), e, c);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    clear_n = 1'b0; q_in = '0; en = 1'b0; clr_err = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Clean rotation: lock on first edge, four revolutions over 25 samples
    for (int i = 0; i < 25; i++) begin
      step(6'(1 << (i % 6)), 1'b1, 1'b0);
      if (i == 0) check("lock_first", int'(locked), 1);
      if (i == 18) check("revs_19", int'(rev_count), 3);
    end
    check("ovf2_cnt", int'(rev_count2), 0);
    check("ovf2_flag", int'(rev_ovf2), 1);

    // Not one-hot while locked, then clear
    do_reset();
    step(6'b000100, 1'b1, 1'b0);
    step(6'b000110, 1'b1, 1'b0);
    check("code_onehot", int'(err_code), 1);
    step(6'b000110, 1'b1, 1'b1);
    check("cleared", int'(error), 0);

    // Stall is an out-of-sequence fault; clr_err outside FAULT has no effect
    do_reset();
    step(6'b000100, 1'b1, 1'b1);
    step(6'b000100, 1'b1, 1'b0);
    check("code_seq", int'(err_code), 2);

    // Disabled cycles ignore corrupted input
    do_reset();
    step(6'b000100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(6'b000000, 1'b0, 1'b0);
    step(6'b001000, 1'b1, 1'b0);
    check("en_resume", int'(locked), 1);

    // Reset mid-revolution with two revolutions counted
    do_reset();
    for (int i = 0; i < 15; i++) step(6'(1 << (i % 6)), 1'b1, 1'b0);
    check("pre_reset", int'(rev_count), 2);
    do_reset();
    step(6'b010000, 1'b1, 1'b0);

    // Random traffic biased towards legal rotation
    for (int n = 0; n < 2000; n++) begin
      int r;
      logic [5:0] q;
      r = $urandom_range(0, 99);
      if (r < 70)
        q = m_locked ? 6'(next_of(m_last)) : 6'(1 << $urandom_range(0, 5));
      else if (r < 85)
        q = 6'($urandom_range(0, 63));
      else if (r < 93)
        q = 6'(1 << $urandom_range(0, 5));
      else
        q = 6'(m_last);
      if ($urandom_range(0, 149) == 0) do_reset();
      step(q, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
